phy_clk_sched: RTL

- Controller/scheduler for the PHY clock divider running on the 8f clock.
- Sequences divider reset release and tracks the 3-bit phase of the f period.
- Emits single-cycle enable strobes for the 4f/2f/f domains.
- Time-shares each f period (8 clk_8f cycles) among NREQ lane requesters with round-robin grants, and handles on-demand phase resync.

---
 rtl/phy_clk_sched_pkg.sv | 25 ++
 rtl/phy_clk_sched_rr_arbiter.sv | 59 +++++
 rtl/phy_clk_sched.sv | 117 +++++++++++
 3 files changed

// File: rtl/phy_clk_sched_pkg.sv
// Shared constants for the PHY clock scheduler: FSM encodings, phase width
// and the phase masks that select each enable strobe.
package phy_clk_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_HOLD   = 2'd0;
  localparam state_t ST_ALIGN  = 2'd1;
  localparam state_t ST_RUN    = 2'd2;
  localparam state_t ST_RESYNC = 2'd3;

  localparam int PHASE_W = 3;
  localparam logic [PHASE_W-1:0] PHASE_LAST = 3'd7;

  // A strobe fires when every bit of its mask is set in the current phase.
  localparam logic [PHASE_W-1:0] MASK_4F = 3'b001;
  localparam logic [PHASE_W-1:0] MASK_2F = 3'b011;
  localparam logic [PHASE_W-1:0] MASK_F  = 3'b111;

  function automatic logic phase_hit(input logic [PHASE_W-1:0] ph,
                                     input logic [PHASE_W-1:0] mask);
    return (ph & mask) == mask;
  endfunction

endpackage

// File: rtl/phy_clk_sched_rr_arbiter.sv
// Round-robin arbiter: on load, grants the first requester after the last
// winner and holds that one-hot grant until the next load or clear.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            load,
  input  logic            clr,
  output logic [NREQ-1:0] grant
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   win;
  logic [PW-1:0]   idx;
  logic            found;

  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = '0;
    // Walk from pointer+1 round to the pointer itself; the first hit wins.
    for (int i = 1; i <= NREQ; i++) begin
      idx = PW'((int'(ptr_q) + i) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (clr) begin
      grant_d = '0;
    end else if (load) begin
      grant_d = found ? (NREQ'(1) << win) : '0;
      if (found) ptr_d = win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      ptr_q   <= PW'(NREQ - 1);
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant = grant_q;

endmodule

// File: rtl/phy_clk_sched.sv
// PHY clock divider scheduler: sequences divider reset release, tracks the
// f-period phase, emits 4f/2f/f strobes and time-shares periods among lanes.
module phy_clk_sched
  import phy_clk_sched_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int NREQ       = 4
) (
  input  logic               clk_8f,
  input  logic               resetCLK,
  input  logic               sync_req,
  input  logic [NREQ-1:0]    req,
  output logic               div_rst_n,
  output logic [PHASE_W-1:0] phase,
  output logic               en_4f,
  output logic               en_2f,
  output logic               en_f,
  output logic               ready,
  output logic [NREQ-1:0]    grant,
  output logic               grant_valid,
  output logic               sync_done
);

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               sync_pend_q, sync_pend_d;
  logic               resync_q, resync_d;
  logic               sync_done_q, sync_done_d;
  logic               arb_load, arb_clr;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = '0;
    sync_pend_d = sync_pend_q;
    arb_load    = 1'b0;
    arb_clr     = 1'b0;
    case (state_q)
      ST_HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_ALIGN;
          cnt_d   = '0;
        end
      end
      ST_ALIGN: begin
        state_d  = ST_RUN;
        arb_load = 1'b1;
      end
      ST_RUN: begin
        phase_d     = phase_q + 1'b1;
        sync_pend_d = sync_pend_q | sync_req;
        if (phase_q == PHASE_LAST) begin
          if (sync_pend_q || sync_req) begin
            state_d = ST_RESYNC;
            arb_clr = 1'b1;
          end else begin
            arb_load = 1'b1;
          end
        end
      end
      ST_RESYNC: begin
        sync_pend_d = 1'b0;
        state_d     = ST_ALIGN;
      end
      default: state_d = ST_HOLD;
    endcase
    // ALIGN remembers whether it was reached through RESYNC.
    resync_d    = (state_q == ST_RESYNC);
    sync_done_d = (state_q == ST_ALIGN) && resync_q;
  end

  always_ff @(posedge clk_8f or negedge resetCLK) begin
    if (!resetCLK) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      phase_q     <= '0;
      sync_pend_q <= 1'b0;
      resync_q    <= 1'b0;
      sync_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      sync_pend_q <= sync_pend_d;
      resync_q    <= resync_d;
      sync_done_q <= sync_done_d;
    end
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk   (clk_8f),
    .rst_n (resetCLK),
    .req   (req),
    .load  (arb_load),
    .clr   (arb_clr),
    .grant (grant)
  );

  assign div_rst_n   = (state_q == ST_ALIGN) || (state_q == ST_RUN);
  assign ready       = (state_q == ST_RUN);
  assign phase       = phase_q;
  assign en_4f       = ready && phase_hit(phase_q, MASK_4F);
  assign en_2f       = ready && phase_hit(phase_q, MASK_2F);
  assign en_f        = ready && phase_hit(phase_q, MASK_F);
  assign grant_valid = |grant;
  assign sync_done   = sync_done_q;

endmodule
